// File: rtl/m0_mem_pkg.sv
// Shared types and helpers for the Cortex-M0 memory port arbiter.
package m0_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // True when an access of the given size cannot be issued at this byte offset.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return (off != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane helper: replicates store data across lanes and extracts
// right-aligned, zero-extended load data from the addressed lane.
module mem_lane_align
  import m0_mem_pkg::*;
(
  input  logic [1:0]  wsize,
  input  logic [31:0] wdata,
  output logic [31:0] wdata_rep,
  input  logic [1:0]  rsize,
  input  logic [1:0]  roff,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic [31:0] rshift;

  // Store data replication so the addressed lane carries the value whatever the offset
  always_comb begin
    case (wsize)
      SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
      SZ_HALF: wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  // Load lane selection by byte offset, then zero extension by size
  always_comb begin
    rshift = rdata >> {roff, 3'b000};
    case (rsize)
      SZ_BYTE: rdata_ext = {24'h0, rshift[7:0]};
      SZ_HALF: rdata_ext = {16'h0, rshift[15:0]};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Load/store has priority; fetch is forced through after STARVE_LIMIT losses.
module mem_port_arbiter
  import m0_mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_WAIT     = 15,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int ST_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
  localparam logic [ST_W-1:0]   STARVE_MAX = ST_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);

  state_t            state, state_nx;
  owner_t            owner;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ST_W-1:0]   starve_cnt;
  logic              if_win, ls_win, ls_misal, done, timeout, finish;
  logic              ls_gnt_q, ls_rvalid_q, ls_err_q;
  logic [DATA_W-1:0] ls_rdata_q;
  logic [31:0]       wdata_rep, rdata_ext;

  assign ls_misal = misaligned(ls_size, ls_addr[1:0]);
  assign finish   = done | timeout;

  mem_lane_align u_lane (
    .wsize     (ls_size),
    .wdata     (ls_wdata),
    .wdata_rep (wdata_rep),
    .rsize     (mem_size),
    .roff      (mem_addr[1:0]),
    .rdata     (mem_rdata),
    .rdata_ext (rdata_ext)
  );

  // Arbitration in IDLE, completion/timeout detection in BUSY, next-state selection
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nx = state;
    ls_win   = 1'b0;
    if_win   = 1'b0;
    done     = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE: begin
        ls_win = ls_req && !(if_req && (starve_cnt == STARVE_MAX));
        if_win = if_req && !ls_win;
        if (ls_win)      state_nx = ls_misal ? ERR : BUSY;
        else if (if_win) state_nx = BUSY;
      end
      BUSY: begin
        // A ready in the last allowed cycle beats the timeout.
        if (mem_ready) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Wait-state and fetch-starvation counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt   <= '0;
      starve_cnt <= '0;
    end else begin
      // Zero outside BUSY, so every access starts counting from 0.
      if (state == BUSY && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
      else                             wait_cnt <= '0;
      if (!if_req || if_win)                      starve_cnt <= '0;
      else if (ls_win && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Latched access fields, grant pulses and registered completion responses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner       <= OWN_IF;
      mem_we      <= 1'b0;
      mem_size    <= SZ_BYTE;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_gnt      <= 1'b0;
      if_rvalid   <= 1'b0;
      if_err      <= 1'b0;
      if_rdata    <= '0;
      ls_gnt_q    <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= '0;
    end else begin
      if_gnt      <= if_win;
      ls_gnt_q    <= ls_win && !ls_misal;
      if_rvalid   <= finish && (owner == OWN_IF);
      if_err      <= timeout && (owner == OWN_IF);
      if_rdata    <= (done && owner == OWN_IF) ? rdata_ext : '0;
      ls_rvalid_q <= finish && (owner == OWN_LS);
      ls_err_q    <= timeout && (owner == OWN_LS);
      ls_rdata_q  <= (done && owner == OWN_LS && !mem_we) ? rdata_ext : '0;
      if (if_win) begin
        owner     <= OWN_IF;
        mem_we    <= 1'b0;
        mem_size  <= SZ_WORD;
        mem_addr  <= if_addr & WORD_MASK;
        mem_wdata <= '0;
      end else if (ls_win && !ls_misal) begin
        owner     <= OWN_LS;
        mem_we    <= ls_we;
        mem_size  <= ls_size;
        mem_addr  <= ls_addr;
        mem_wdata <= wdata_rep;
      end
    end
  end

  // The misalignment reject answers in the ERR cycle itself.
  assign ls_gnt    = ls_gnt_q    | (state == ERR);
  assign ls_rvalid = ls_rvalid_q | (state == ERR);
  assign ls_err    = ls_err_q    | (state == ERR);
  assign ls_rdata  = ls_rdata_q;
  assign mem_req   = (state == BUSY);
  assign busy      = (state != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter and access sequencer between the Cortex-M0 instruction-fetch path and the load/store path of the Datapath. Both requesters share one memory port with variable wait states. Load/store has fixed priority, with a starvation guard for fetch. The block also performs byte-lane alignment, misalignment rejection and wait-state timeout, and its `busy` output lets the ControlUnit stall the fetch/decode/execute sequence.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (fixed 32 for lane logic)
- `MAX_WAIT`, 15, wait cycles without `mem_ready` before abort
- `STARVE_LIMIT`, 3, consecutive fetch losses before fetch is forced to win

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `if_req`  in  1  fetch request, held until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address, bits [1:0] ignored
- `if_gnt`  out  1  fetch accepted (1-cycle pulse)
- `if_rvalid`  out  1  fetch complete (1-cycle pulse)
- `if_rdata`  out  DATA_W  fetched word
- `if_err`  out  1  qualifies `if_rvalid`: timeout
- `ls_req`  in  1  load/store request, held until `ls_gnt`
- `ls_we`  in  1  1 = store
- `ls_size`  in  2  0 = byte, 1 = half, 2 = word (3 is treated as misaligned)
- `ls_addr`  in  ADDR_W  byte address
- `ls_wdata`  in  DATA_W  store data, right-aligned
- `ls_gnt`  out  1  load/store accepted (1-cycle pulse)
- `ls_rvalid`  out  1  load/store complete (1-cycle pulse)
- `ls_rdata`  out  DATA_W  load data, zero-extended, right-aligned; 0 on store or error
- `ls_err`  out  1  qualifies `ls_rvalid`: misaligned access or timeout
- `mem_req`  out  1  memory access active
- `mem_we`, `mem_size`, `mem_addr`, `mem_wdata`  out  1/2/ADDR_W/DATA_W  latched access fields
- `mem_ready`  in  1  memory completes access this cycle
- `mem_rdata`  in  DATA_W  read data, valid when `mem_ready` is high
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states:
  - IDLE: arbitrate.
  - BUSY: memory access in progress.
  - ERR: one-cycle misalignment reject.
- Arbitration in IDLE:
  - Only one requester → that requester wins.
  - Both requesting → LS wins, unless `starve_cnt == STARVE_LIMIT`, in which case IF wins.
- `starve_cnt`:
  - Increments when IF loses.
  - Clears when IF wins or `if_req` is low.
  - Saturates at `STARVE_LIMIT`.
- Misalignment, checked only for an LS winner: half with addr[0] set; word with addr[1:0] ≠ 0; size 3. A misaligned winner goes to ERR.
- Aligned winner → BUSY. Owner and fields are latched.
  - Fetch: `mem_addr` = {addr[31:2], 2'b00}, size = word.
  - Store data is replicated per size: byte ×4, half ×2.
- BUSY:
  - `mem_req` = 1 every cycle.
  - On `mem_ready` → IDLE. The owner gets `rvalid`, plus registered `rdata`.
  - Load of byte/half: lane selected by addr[1:0], then zero-extended.
  - Store: `rvalid` acknowledges completion, `rdata` = 0.
- Wait counter:
  - Clears on entry to BUSY.
  - Increments each BUSY cycle without `mem_ready`.
  - Reaches `MAX_WAIT` → IDLE. The owner gets `rvalid` = 1 and `err` = 1, `rdata` = 0, and `mem_req` drops.
- ERR: `ls_gnt`, `ls_rvalid` and `ls_err` all = 1 in the same cycle; `mem_req` = 0; next state IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, both counters 0. Asserting reset mid-access drops `mem_req` immediately and produces no `rvalid`.
- Request sampled high in IDLE at edge N → BUSY from edge N. `gnt` and `mem_req` are high in the first BUSY cycle.
- `mem_ready` in the first BUSY cycle → `rvalid` in the following cycle. Minimum latency: request to `rvalid` = 2 cycles.
- The `rvalid` cycle is an IDLE cycle and can accept a new request. Peak throughput is 1 access per 2 cycles.
- A request dropped before `gnt` violates protocol. A request dropped after `gnt` is ignored.
- Simultaneous `mem_ready` and timeout: `mem_ready` wins, and the access completes without error.
- `mem_*` outputs hold stable throughout BUSY.

## Structure
- Package `m0_mem_pkg` holds:
  - state enum {IDLE, BUSY, ERR}
  - owner enum {OWN_IF, OWN_LS}
  - size constants SZ_BYTE/SZ_HALF/SZ_WORD
  - misalignment function
- One sub-module, `mem_lane_align`: combinational write replication and read lane extraction (zero-extend) by size and addr[1:0].

## Test plan
- Single fetch, `if_addr` = 0x0000_0106, `mem_ready` in the first BUSY cycle, `mem_rdata` = 0xDEAD_BEEF → `mem_addr` = 0x104; `if_rvalid` 2 cycles after request; `if_rdata` = 0xDEADBEEF.
- Load byte at 0x2000_0003, `mem_rdata` = 0xAB12_3456 → `ls_rdata` = 0x0000_00AB. Store half at 0x2000_0002, `ls_wdata` = 0x1234 → `mem_wdata` = 0x1234_1234.
- Both requesting continuously, `mem_ready` always high → grant order LS, LS, LS, IF, LS…; IF is granted after exactly 3 losses.
- Word load at 0x2000_0001 → ERR: `ls_gnt`, `ls_rvalid` and `ls_err` high for 1 cycle, `mem_req` never asserted.
- Fetch with `mem_ready` held low → after 15 BUSY cycles, `if_rvalid` = 1 and `if_err` = 1, `mem_req` = 0. Ready and timeout coincident → no error.
- `rst` low in mid-BUSY → all outputs 0 asynchronously. Re-requesting after release completes normally.
